// File: rtl/uart_tx.sv
// UART transmitter: start bit, MSB-first data, optional even parity, stop bits.
// Bit timing from an internal baud divider; Tx is driven from a register.
module uart_tx #(
    parameter int SYSCLK_RATE  = 100000000,
    parameter int BAUD_RATE    = 9600,
    parameter int CLKS_PER_BIT = SYSCLK_RATE / BAUD_RATE,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_BIT   = 1,
    parameter int STOP_BITS    = 2
) (
    input  logic                 SysClk,
    input  logic                 Rst,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 Transmit_Start,
    input  logic                 CTS,
    output logic                 Tx,
    output logic                 Tx_Busy,
    output logic                 Tx_Done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     baud_cnt;
    logic [CNT_W-1:0]     baud_next;
    logic [3:0]           bit_cnt;
    logic [3:0]           bit_next;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_next;
    logic                 par;
    logic                 par_next;
    logic                 tx_next;
    logic                 busy_next;
    logic                 done_next;
    logic                 wrap;
    logic                 accept;
    logic                 last_data;
    logic                 last_stop;

    assign wrap      = baud_cnt == CNT_W'(CLKS_PER_BIT - 1);
    assign accept    = (state == IDLE) && Transmit_Start && CTS;
    assign last_data = bit_cnt == 4'(DATA_BITS - 1);
    assign last_stop = bit_cnt == 4'(STOP_BITS - 1);

    // State register
    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: every advance happens on a baud wrap
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = START;
            START:   if (wrap) state_next = DATA;
            DATA:    if (wrap && last_data)
                         state_next = (PARITY_BIT != 0) ? PARITY : STOP;
            PARITY:  if (wrap) state_next = STOP;
            STOP:    if (wrap && last_stop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter, shift register and parity next values
    always_comb begin
        baud_next  = (state == IDLE || wrap) ? '0 : baud_cnt + 1'b1;
        if (state_next != state) bit_next = '0;
        else if (wrap)           bit_next = bit_cnt + 1'b1;
        else                     bit_next = bit_cnt;
        shreg_next = shreg;
        par_next   = par;
        if (accept) begin
            shreg_next = Tx_Data;
            par_next   = ^Tx_Data;
        end else if (state == DATA && wrap) begin
            shreg_next = shreg << 1;
        end
    end

    // Output next values, derived from where the FSM is heading
    always_comb begin
        tx_next = 1'b1;
        unique case (state_next)
            IDLE:    tx_next = 1'b1;
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[DATA_BITS-1];
            PARITY:  tx_next = par_next;
            STOP:    tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
        busy_next = state_next != IDLE;
        done_next = (state == STOP) && (state_next == IDLE);
    end

    // Datapath and registered outputs
    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            Tx       <= 1'b1;
            Tx_Busy  <= 1'b0;
            Tx_Done  <= 1'b0;
        end else begin
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shreg    <= shreg_next;
            par      <= par_next;
            Tx       <= tx_next;
            Tx_Busy  <= busy_next;
            Tx_Done  <= done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table vectors, random frames against a bit-list model,
// plus CTS hold-off, back-to-back and mid-frame reset sequences.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       start = 1'b0;
    logic       cts = 1'b0;
    logic       tx_p, busy_p, done_p;
    logic       tx_n, busy_n, done_n;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [7:0] data;
        bit         pe;
        int         exp_len;
        logic       exp_par;
    } vec_t;

    always #5 clk = ~clk;

    uart_tx #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_BIT(1), .STOP_BITS(2)
    ) dut_p (
        .SysClk(clk), .Rst(rst), .Tx_Data(tx_data),
        .Transmit_Start(start), .CTS(cts),
        .Tx(tx_p), .Tx_Busy(busy_p), .Tx_Done(done_p)
    );

    uart_tx #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_BIT(0), .STOP_BITS(2)
    ) dut_n (
        .SysClk(clk), .Rst(rst), .Tx_Data(tx_data),
        .Transmit_Start(start), .CTS(cts),
        .Tx(tx_n), .Tx_Busy(busy_n), .Tx_Done(done_n)
    );

    function automatic logic s_tx(bit sel);
        return sel ? tx_n : tx_p;
    endfunction

    function automatic logic s_busy(bit sel);
        return sel ? busy_n : busy_p;
    endfunction

    function automatic logic s_done(bit sel);
        return sel ? done_n : done_p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: list of line bits for the frame, each stretched to CPB cycles
    function automatic void model(input logic [7:0] d, input bit pe,
                                  output logic [63:0] w, output int n);
        bit q[$];
        q.push_back(1'b0);
        for (int i = 7; i >= 0; i--) q.push_back(d[i]);
        if (pe) q.push_back(^d);
        q.push_back(1'b1);
        q.push_back(1'b1);
        w = '0;
        n = 0;
        foreach (q[i]) begin
            repeat (CPB) begin
                w[n] = q[i];
                n++;
            end
        end
    endfunction

    task automatic capture(input bit sel, output logic [63:0] w,
                           output int n, output int dn);
        w  = '0;
        n  = 0;
        dn = 0;
        while (s_busy(sel) && n < 200) begin
            if (n < 64) w[n] = s_tx(sel);
            n++;
            @(posedge clk); #1;
            if (s_done(sel)) dn++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL capture timeout: busy stuck, got %0d cycles", n);
        end
    endtask

    task automatic check_frame(input string name, input bit sel,
                               input logic [7:0] d, input int exp_len,
                               input logic exp_par);
        logic [63:0] w, ew;
        int          n, dn, el;
        model(d, !sel, ew, el);
        capture(sel, w, n, dn);
        chk({name, " wave"}, w, ew);
        chk({name, " len"}, 64'(n), 64'(exp_len));
        if (!sel) chk({name, " parity"}, 64'(w[9*CPB+1]), 64'(exp_par));
        chk({name, " done"}, 64'(dn), 64'd1);
        chk({name, " idle tx"}, 64'(s_tx(sel)), 64'd1);
        @(posedge clk); #1;
        chk({name, " done drop"}, 64'(s_done(sel)), 64'd0);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy_p || busy_n) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout: got busy after %0d cycles", k);
        end
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] d, input bit sel, input bit hold);
        wait_idle();
        tx_data = d;
        start   = 1'b1;
        cts     = 1'b1;
        @(posedge clk); #1;
        chk("accept busy", 64'(s_busy(sel)), 64'd1);
        chk("accept tx", 64'(s_tx(sel)), 64'd0);
        if (!hold) start = 1'b0;
    endtask

    initial begin
        vec_t       tbl[6];
        logic [7:0] d;
        bit         pe;
        int         bad;

        tbl[0] = '{8'hA5, 1'b1, 48, 1'b0};
        tbl[1] = '{8'h01, 1'b1, 48, 1'b1};
        tbl[2] = '{8'h01, 1'b0, 44, 1'b0};
        tbl[3] = '{8'h00, 1'b1, 48, 1'b0};
        tbl[4] = '{8'hFF, 1'b1, 48, 1'b0};
        tbl[5] = '{8'h80, 1'b0, 44, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset tx", 64'(tx_p), 64'd1);
        chk("reset busy", 64'(busy_p), 64'd0);
        chk("reset done", 64'(done_p), 64'd0);
        chk("reset tx_n", 64'(tx_n), 64'd1);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            send(tbl[i].data, !tbl[i].pe, 1'b0);
            check_frame($sformatf("vec%0d", i), !tbl[i].pe, tbl[i].data,
                        tbl[i].exp_len, tbl[i].exp_par);
        end

        repeat (8) begin
            d  = 8'($urandom);
            pe = 1'($urandom_range(0, 1));
            send(d, !pe, 1'b0);
            check_frame($sformatf("rand %02h", d), !pe, d,
                        (11 + int'(pe)) * CPB, ^d);
        end

        // CTS low holds the request off
        wait_idle();
        tx_data = 8'h96;
        start   = 1'b1;
        cts     = 1'b0;
        bad     = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (tx_p !== 1'b1 || busy_p !== 1'b0) bad++;
        end
        chk("cts hold", 64'(bad), 64'd0);
        cts = 1'b1;
        @(posedge clk); #1;
        chk("cts go busy", 64'(busy_p), 64'd1);
        chk("cts go tx", 64'(tx_p), 64'd0);
        start = 1'b0;
        check_frame("cts frame", 1'b0, 8'h96, 48, 1'b0);

        // Back-to-back with mid-frame CTS drop and data change
        send(8'h3C, 1'b0, 1'b1);
        fork
            begin
                repeat (10) @(posedge clk);
                #2;
                cts     = 1'b0;
                tx_data = 8'hC3;
                repeat (20) @(posedge clk);
                #2;
                cts = 1'b1;
            end
            check_frame("b2b first", 1'b0, 8'h3C, 48, 1'b0);
        join
        chk("b2b gap busy", 64'(busy_p), 64'd1);
        chk("b2b gap tx", 64'(tx_p), 64'd0);
        start = 1'b0;
        check_frame("b2b second", 1'b0, 8'hC3, 48, 1'b0);

        // Reset during data bit 5 truncates the frame
        send(8'h5A, 1'b0, 1'b0);
        repeat (25) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst tx", 64'(tx_p), 64'd1);
        chk("midrst busy", 64'(busy_p), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (tx_p !== 1'b1 || busy_p !== 1'b0 || done_p !== 1'b0) bad++;
        end
        chk("midrst idle", 64'(bad), 64'd0);
        send(8'h69, 1'b0, 1'b0);
        check_frame("after rst", 1'b0, 8'h69, 48, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
